// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding
// and read-response decoding.
package ifu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } ifu_state_t;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   // Any response code other than OKAY marks the fetched word as faulting.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/ifu_reg.sv
// Generic data register with synchronous active-high reset and write enable.
module ifu_reg #(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Load d when enabled; reset forces the configured value.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RST_VAL;
      end else if (wen) begin
         q <= d;
      end
   end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding read per instruction, a
// valid/ready handoff to decode, and redirect handling that discards any
// response belonging to the stale path.
module ifu
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h80000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        pc_b_j,
   output logic        ifu_arvalid,
   output logic [31:0] ifu_araddr,
   input  logic        ifu_arready,
   input  logic        ifu_rvalid,
   input  logic [31:0] ifu_rdata,
   input  logic [1:0]  ifu_rresp,
   output logic        ifu_rready,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_err,
   output logic        if_id_handshake
);

   ifu_state_t  state_reg, state_next;
   logic        drop_reg, drop_next;
   logic        araddr_wen;
   logic        req_pc_wen;
   logic        capture_wen;
   logic [31:0] req_pc;
   logic        rresp_err;

   assign rresp_err = resp_is_err(ifu_rresp);

   // State and stale-response marker registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         drop_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         drop_reg  <= drop_next;
      end
   end

   // Next-state logic plus write enables for the datapath registers.
   always_comb begin
      state_next  = state_reg;
      drop_next   = drop_reg;
      araddr_wen  = 1'b0;
      req_pc_wen  = 1'b0;
      capture_wen = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            // A redirect this cycle means pc is about to change; wait for it.
            if (!pc_b_j) begin
               state_next = ST_REQ;
               araddr_wen = 1'b1;
            end
         end
         ST_REQ: begin
            // The request cannot be withdrawn, so a redirect only marks it stale.
            if (pc_b_j) begin
               drop_next = 1'b1;
            end
            if (ifu_arready) begin
               state_next = ST_WAIT;
               req_pc_wen = 1'b1;
            end
         end
         ST_WAIT: begin
            if (ifu_rvalid) begin
               if (drop_reg || pc_b_j) begin
                  drop_next  = 1'b0;
                  state_next = ST_IDLE;
               end else begin
                  capture_wen = 1'b1;
                  state_next  = ST_HOLD;
               end
            end else if (pc_b_j) begin
               drop_next = 1'b1;
            end
         end
         ST_HOLD: begin
            // Redirect wins over if_ready: the held instruction is killed.
            if (pc_b_j || if_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign ifu_arvalid     = (state_reg == ST_REQ);
   assign ifu_rready      = (state_reg == ST_WAIT);
   assign if_valid        = (state_reg == ST_HOLD);
   assign if_id_handshake = if_valid & if_ready & ~pc_b_j;

   ifu_reg #(.WIDTH(32), .RST_VAL(RESET_PC)) u_araddr (
      .clk (clk),
      .rst (rst),
      .wen (araddr_wen),
      .d   (pc),
      .q   (ifu_araddr)
   );

   ifu_reg #(.WIDTH(32), .RST_VAL(32'h0)) u_req_pc (
      .clk (clk),
      .rst (rst),
      .wen (req_pc_wen),
      .d   (ifu_araddr),
      .q   (req_pc)
   );

   ifu_reg #(.WIDTH(32), .RST_VAL(32'h0)) u_if_pc (
      .clk (clk),
      .rst (rst),
      .wen (capture_wen),
      .d   (req_pc),
      .q   (if_pc)
   );

   ifu_reg #(.WIDTH(32), .RST_VAL(32'h0)) u_if_inst (
      .clk (clk),
      .rst (rst),
      .wen (capture_wen),
      .d   (ifu_rdata),
      .q   (if_inst)
   );

   ifu_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_if_err (
      .clk (clk),
      .rst (rst),
      .wen (capture_wen),
      .d   (rresp_err),
      .q   (if_err)
   );

endmodule

// File: tb/tb_ifu.sv
// Testbench for ifu: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of the PC unit and memory.
module tb_ifu;

   localparam logic [31:0] RESET_PC = 32'h80000000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        pc_b_j;
   logic        ifu_arvalid;
   logic [31:0] ifu_araddr;
   logic        ifu_arready;
   logic        ifu_rvalid;
   logic [31:0] ifu_rdata;
   logic [1:0]  ifu_rresp;
   logic        ifu_rready;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_err;
   logic        if_id_handshake;

   always #5 clk = ~clk;

   ifu #(.RESET_PC(RESET_PC)) dut (
      .clk             (clk),
      .rst             (rst),
      .pc              (pc),
      .pc_b_j          (pc_b_j),
      .ifu_arvalid     (ifu_arvalid),
      .ifu_araddr      (ifu_araddr),
      .ifu_arready     (ifu_arready),
      .ifu_rvalid      (ifu_rvalid),
      .ifu_rdata       (ifu_rdata),
      .ifu_rresp       (ifu_rresp),
      .ifu_rready      (ifu_rready),
      .if_valid        (if_valid),
      .if_ready        (if_ready),
      .if_pc           (if_pc),
      .if_inst         (if_inst),
      .if_err          (if_err),
      .if_id_handshake (if_id_handshake)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Memory contents: a fixed scramble of the address (0x413 at the reset PC).
   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return ((a - RESET_PC) * 32'h9E3779B1) ^ 32'h00000413;
   endfunction

   // Addresses with bits [4:2] == 3 return an error response.
   function automatic logic err_of(input logic [31:0] a);
      return (a[4:2] == 3'b011);
   endfunction

   // Knobs: arready mode (1 always, 0 random), latency (-1 random),
   // if_ready (0/1/2=random), flush mode (0 none, 1 in WAIT w/o rvalid,
   // 2 when if_valid, 3 random, 4 in REQ), redirect target.
   int          k_ar, k_lat, k_ready, k_flush;
   logic [31:0] k_dnpc;

   // Reference model: PC unit, single-slot memory and redirect epochs.
   logic [31:0] m_pc;
   bit          m_out;
   int          m_lat;
   logic [31:0] m_addr;
   int          epoch, req_epoch;
   bit          exp_known, exp_valid;
   bit          p_ar_pend, p_hold_stay, p_hold_exit;
   logic [31:0] p_araddr;

   // Observations from the most recent cycle.
   logic        o_arvalid, o_rready, o_valid, o_hs, o_err, o_flush, o_ar_fire, o_r_fire;
   logic [31:0] o_araddr, o_pc, o_inst;
   bit          seen_valid;

   task automatic tick();
      ifu_arready = (k_ar == 1) ? 1'b1 : ($urandom % 3 != 0);
      if (m_out && m_lat == 0) begin
         ifu_rvalid = 1'b1;
         ifu_rdata  = inst_of(m_addr);
         ifu_rresp  = err_of(m_addr) ? 2'b10 : 2'b00;
      end else begin
         ifu_rvalid = 1'b0;
         ifu_rdata  = $urandom;
         ifu_rresp  = 2'($urandom);
         if (m_out) m_lat--;
      end
      if_ready = (k_ready == 2) ? 1'($urandom) : (k_ready != 0);
      case (k_flush)
         1:       pc_b_j = ifu_rready && !ifu_rvalid;
         2:       pc_b_j = if_valid;
         3:       pc_b_j = ($urandom % 10 == 0);
         4:       pc_b_j = ifu_arvalid;
         default: pc_b_j = 1'b0;
      endcase
      if (k_flush == 3) k_dnpc = RESET_PC + (32'($urandom_range(0, 1023)) << 2);
      if (pc_b_j && k_flush != 3) k_flush = 0;

      @(negedge clk);
      o_arvalid = ifu_arvalid;  o_araddr = ifu_araddr;  o_rready = ifu_rready;
      o_valid   = if_valid;     o_pc     = if_pc;       o_inst   = if_inst;
      o_err     = if_err;       o_hs     = if_id_handshake;
      o_flush   = pc_b_j;
      o_ar_fire = ifu_arvalid & ifu_arready;
      o_r_fire  = ifu_rvalid & ifu_rready;
      if (!rst) begin
         if (m_out) begin
            check("one_outstanding", o_arvalid, 0);
            check("rready_wait", o_rready, 1);
         end else begin
            check("rready_idle", o_rready, 0);
         end
         if (p_ar_pend) begin
            check("ar_hold", o_arvalid, 1);
            check("araddr_stable", o_araddr, p_araddr);
         end else if (o_arvalid) begin
            check("araddr_pc", o_araddr, pc);
            req_epoch = epoch;
         end
         if (o_valid) begin
            check("if_pc", o_pc, pc);
            check("if_inst", o_inst, inst_of(pc));
            check("if_err", o_err, err_of(pc));
         end
         check("handshake", o_hs, if_valid & if_ready & ~pc_b_j);
         if (exp_known)   check("deliver", o_valid, exp_valid);
         if (p_hold_stay) check("hold_valid", o_valid, 1);
         if (p_hold_exit) check("hold_exit", o_valid, 0);
      end
      p_ar_pend   = o_arvalid & ~ifu_arready;
      p_araddr    = o_araddr;
      p_hold_stay = o_valid & ~o_hs & ~o_flush;
      p_hold_exit = o_valid & (o_hs | o_flush);
      exp_known   = o_r_fire;
      exp_valid   = (req_epoch == epoch) && !o_flush;

      @(posedge clk);
      #1;
      if (rst) begin
         m_pc = RESET_PC;  m_out = 0;  p_ar_pend = 0;  p_hold_stay = 0;
         p_hold_exit = 0;  exp_known = 0;
      end else begin
         if (o_flush) begin
            m_pc = k_dnpc;
            epoch++;
         end else if (o_hs) begin
            m_pc = m_pc + 32'd4;
         end
         if (o_r_fire) m_out = 0;
         if (o_ar_fire) begin
            m_out  = 1;
            m_addr = o_araddr;
            m_lat  = (k_lat < 0) ? int'($urandom_range(0, 4)) : k_lat;
         end
      end
      pc = m_pc;
   endtask

   // what: 0 if_valid, 1 arvalid, 2 rready, 3 flush applied
   task automatic run_until(input int what, input int max_cycles);
      bit hit;
      hit = 0;
      seen_valid = 0;
      for (int i = 0; i < max_cycles && !hit; i++) begin
         tick();
         seen_valid |= o_valid;
         case (what)
            0:       hit = o_valid;
            1:       hit = o_arvalid;
            2:       hit = o_rready;
            default: hit = o_flush;
         endcase
      end
      check($sformatf("timeout_%0d", what), 32'(hit), 1);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_arvalid"}, o_arvalid, 0);
      check({pfx, "_rready"},  o_rready, 0);
      check({pfx, "_valid"},   o_valid, 0);
      check({pfx, "_hs"},      o_hs, 0);
      check({pfx, "_araddr"},  o_araddr, RESET_PC);
      check({pfx, "_if_pc"},   o_pc, 0);
      check({pfx, "_if_inst"}, o_inst, 0);
      check({pfx, "_if_err"},  o_err, 0);
   endtask

   initial begin
      logic [31:0] hold_pc, hold_inst;
      int          idle;
      k_ar = 1;  k_lat = 0;  k_ready = 1;  k_flush = 0;  k_dnpc = RESET_PC;
      m_pc = RESET_PC;  m_out = 0;  m_lat = 0;  m_addr = 0;
      epoch = 0;  req_epoch = 0;  exp_known = 0;  exp_valid = 0;
      p_ar_pend = 0;  p_hold_stay = 0;  p_hold_exit = 0;  p_araddr = 0;
      pc = RESET_PC;  pc_b_j = 0;  if_ready = 0;
      ifu_arready = 0;  ifu_rvalid = 0;  ifu_rdata = 0;  ifu_rresp = 0;
      rst = 1;

      // Reset release with a single-cycle memory.
      tick();
      tick();
      rst = 0;
      tick();
      check_reset_outputs("rst");
      tick();
      check("c1_arvalid", o_arvalid, 1);
      check("c1_araddr", o_araddr, 32'h80000000);
      tick();
      check("c2_rready", o_rready, 1);
      tick();
      check("c3_valid", o_valid, 1);
      check("c3_pc", o_pc, 32'h80000000);
      check("c3_inst", o_inst, 32'h00000413);
      check("c3_hs", o_hs, 1);

      // Decode backpressure.
      k_ready = 0;
      run_until(0, 10);
      check("bp_pc", o_pc, 32'h80000004);
      hold_pc = o_pc;
      hold_inst = o_inst;
      repeat (5) begin
         tick();
         check("bp_valid", o_valid, 1);
         check("bp_pc_stable", o_pc, hold_pc);
         check("bp_inst_stable", o_inst, hold_inst);
         check("bp_no_ar", o_arvalid, 0);
         check("bp_no_hs", o_hs, 0);
      end
      k_ready = 1;
      tick();
      check("bp_hs", o_hs, 1);
      tick();
      check("bp_exit", o_valid, 0);

      // Redirect while the response is still pending.
      k_lat = 3;  k_dnpc = 32'h80000100;  k_flush = 1;
      run_until(3, 20);
      k_lat = 0;
      run_until(1, 20);
      check("wflush_no_valid", 32'(seen_valid), 0);
      check("wflush_addr", o_araddr, 32'h80000100);
      run_until(0, 10);
      check("wflush_pc", o_pc, 32'h80000100);

      // Redirect and if_ready in the same HOLD cycle.
      k_dnpc = 32'h80000200;  k_flush = 2;
      run_until(0, 10);
      check("hflush_hs", o_hs, 0);
      check("hflush_pc", o_pc, 32'h80000104);
      tick();
      check("hflush_idle_valid", o_valid, 0);
      check("hflush_idle_ar", o_arvalid, 0);
      tick();
      check("hflush_ar", o_arvalid, 1);
      check("hflush_addr", o_araddr, 32'h80000200);
      run_until(0, 10);

      // Error response followed by a normal one.
      k_dnpc = 32'h8000000C;  k_flush = 2;
      run_until(0, 10);
      run_until(0, 10);
      check("err_pc", o_pc, 32'h8000000C);
      check("err_flag", o_err, 1);
      run_until(0, 10);
      check("ok_pc", o_pc, 32'h80000010);
      check("ok_flag", o_err, 0);

      // Reset asserted while waiting for read data.
      k_lat = 3;
      run_until(2, 10);
      rst = 1;
      tick();
      rst = 0;
      k_lat = 0;
      tick();
      check_reset_outputs("wrst");
      tick();
      check("wrst_ar", o_arvalid, 1);
      check("wrst_addr", o_araddr, 32'h80000000);

      // Randomized traffic with redirects, stalls and occasional resets.
      k_ar = 0;  k_lat = -1;  k_ready = 2;  k_flush = 3;
      idle = 0;
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 399) == 0);
         tick();
         if (o_hs || rst) begin
            idle = 0;
         end else if (++idle > 400) begin
            check("progress", o_hs, 1);
            idle = 0;
         end
      end
      rst = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ifu.md
# ifu

Instruction Fetch Unit: consumes the current PC from the program counter unit, issues one read per instruction on the instruction-memory read channel, and presents the fetched instruction to ID with a valid/ready handshake. It generates `if_id_handshake`, which advances the PC. It also honours `pc_b_j` redirects by killing or discarding any fetch belonging to the stale path.

## Interface
Parameters:
- `RESET_PC`, default 32'h80000000: reset value of the internal request-address register.

Ports:
- `clk`  in  1  system clock; everything sampled on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `pc`  in  32  current PC from the PC unit; changes only on the edge after `if_id_handshake` or `pc_b_j`.
- `pc_b_j`  in  1  redirect/flush from EXU. The same signal that loads `dnpc` into the PC.
- `ifu_arvalid`  out  1  read request valid.
- `ifu_araddr`  out  32  read address, registered.
- `ifu_arready`  in  1  memory accepts the request.
- `ifu_rvalid`  in  1  read data valid.
- `ifu_rdata`  in  32  read data.
- `ifu_rresp`  in  2  response code: 2'b00 OKAY, anything else is an error.
- `ifu_rready`  out  1  IFU accepts read data.
- `if_valid`  out  1  instruction valid toward ID.
- `if_ready`  in  1  ID accepts the instruction.
- `if_pc`  out  32  PC of the presented instruction.
- `if_inst`  out  32  presented instruction word.
- `if_err`  out  1  access fault flag for the presented instruction.
- `if_id_handshake`  out  1  `if_valid & if_ready & ~pc_b_j`; drives PC advance.

## Operation
The FSM has four states: IDLE, REQ, WAIT, HOLD. There is also a 1-bit `drop` register.

State outputs:
- `ifu_arvalid` = (state==REQ).
- `ifu_rready` = (state==WAIT).
- `if_valid` = (state==HOLD).

Transitions:
- **IDLE**
  - `pc_b_j`=1: stay in IDLE. The PC is about to change.
  - Otherwise: go to REQ and load `ifu_araddr <= pc`.
- **REQ**
  - `ifu_arready`=1: go to WAIT and latch `req_pc <= ifu_araddr`.
  - `ifu_araddr` stays stable while `ifu_arvalid` is high; a request is never withdrawn.
  - `pc_b_j`=1: set `drop`. This also applies in the same cycle as `ifu_arready`.
- **WAIT**
  - `ifu_rvalid`=1 and (`drop` | `pc_b_j`): discard the data, clear `drop`, go to IDLE.
  - `ifu_rvalid`=1, otherwise: capture `if_inst <= ifu_rdata`, `if_pc <= req_pc`, `if_err <= (ifu_rresp != 0)`, then go to HOLD.
  - `ifu_rvalid`=0 and `pc_b_j`=1: set `drop`.
- **HOLD**
  - `pc_b_j`=1: kill the instruction (no handshake) and go to IDLE. Flush has priority over `if_ready`.
  - `if_ready`=1: handshake, then go to IDLE.
  - `if_pc`, `if_inst` and `if_err` are held stable throughout HOLD.

Error responses travel down the pipeline like normal instructions; the IFU itself takes no other action on them.

## Timing
Reset values:
- state IDLE, `drop` 0, `ifu_araddr` `RESET_PC`.
- `if_pc`, `if_inst`, `if_err` all 0.
- Hence `ifu_arvalid`, `ifu_rready`, `if_valid`, `if_id_handshake` are all 0.

Reset asserted mid-operation:
- Forces IDLE on the next edge and abandons any outstanding response.
- The memory side is reset by the same `rst`.

Throughput and latency:
- Minimum is 4 cycles per instruction: IDLE, REQ (with `arready`), WAIT (with `rvalid`), HOLD (with `if_ready`).
- `if_valid` rises at the earliest 3 cycles after leaving reset.
- Read data is never accepted in the same cycle as the request.

PC stability:
- The PC unit updates on the edge that ends HOLD or a flush cycle.
- Passing through IDLE guarantees the registered PC is the new one before the next REQ samples it.

Outstanding reads:
- At most one read is outstanding.
- After a redirect, exactly one response is discarded if one was pending.

## Structure
- State encodings (2-bit) and the `RESP_OKAY` constant belong in `common.v`, alongside the existing shared defines.
- Data registers (`ifu_araddr`, `req_pc`, `if_pc`, `if_inst`, `if_err`) use the existing `Reg` module with write enables.
- The FSM is a single always block inside `ifu`; no further sub-module.

## Test plan
- **Reset release, single-cycle memory:** `arready`=1, `rvalid` one cycle after the request, `rdata`=32'h00000413, `if_ready`=1.
  - Request to 32'h80000000 in cycle 1.
  - `if_valid` with `if_pc`=80000000 and `if_inst`=00000413 in cycle 3.
  - `if_id_handshake` pulses in cycle 3.
- **ID backpressure:** `if_ready`=0 for 5 cycles.
  - `if_valid` is held with stable `if_pc`/`if_inst`.
  - No new `ifu_arvalid` until after the handshake.
- **Flush during WAIT:** `pc_b_j` pulses with `dnpc`=80000100 while `rvalid` is low; the response arrives later.
  - The response is discarded and `if_valid` never rises for it.
  - The next request address is 80000100.
- **Flush and `if_ready` in the same HOLD cycle:**
  - `if_id_handshake`=0 and the FSM returns to IDLE.
  - The next fetch uses the redirected PC.
- **Error response:** `rresp`=2'b10.
  - `if_err`=1 is delivered with the instruction.
  - The next fetch proceeds normally with `if_err`=0 after an OKAY response.
- **Reset asserted in WAIT:** all outputs return to their reset values on the next edge, and fetch restarts at 80000000.
